// File: rtl/snake_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_pkg                                                            |
// | Direction type, encodings and press-decoding helpers for Snake.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_RIGHT = 2'd1;
  localparam dir_t DIR_DOWN  = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  function automatic dir_t dir_rev(input dir_t d);
    return d ^ 2'b10;
  endfunction

  // press vector ordered [3]=UP [2]=DOWN [1]=LEFT [0]=RIGHT
  function automatic dir_t btn_to_dir(input logic [3:0] press);
    dir_t d;
    if (press[0])      d = DIR_RIGHT;
    else if (press[1]) d = DIR_LEFT;
    else if (press[2]) d = DIR_DOWN;
    else               d = DIR_UP;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_dir_if                                                         |
// | Button / tick inputs and direction-queue outputs for all players.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface snake_dir_if #(
  parameter int NUM_PLAYERS = 1,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [4*NUM_PLAYERS-1:0]  btn_n;
  logic                      step;
  logic [2*NUM_PLAYERS-1:0]  dir_out;
  logic [NUM_PLAYERS-1:0]    turn_pulse;
  logic [NUM_PLAYERS-1:0]    drop_pulse;
  logic [NUM_PLAYERS*CW-1:0] q_count;

  modport master (output btn_n, step,
                  input  dir_out, turn_pulse, drop_pulse, q_count);
  modport slave  (input  btn_n, step,
                  output dir_out, turn_pulse, drop_pulse, q_count);
endinterface
`default_nettype wire

// File: rtl/snake_dir_queue_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_dir_chan                                                       |
// | One player: button sync, press detect, turn filter, turn FIFO.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snake_dir_chan
  import snake_pkg::*;
#(
  parameter int   QUEUE_DEPTH = 4,
  parameter dir_t RESET_DIR   = DIR_LEFT,
  localparam int  CW = $clog2(QUEUE_DEPTH + 1),
  localparam int  PW = $clog2(QUEUE_DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    btn_n,
  input  logic          step,
  output dir_t          dir_out,
  output logic          turn_pulse,
  output logic          drop_pulse,
  output logic [CW-1:0] q_count
);

  localparam logic [CW-1:0] C_FULL = CW'(QUEUE_DEPTH);

  logic [3:0]    r_sync1, r_sync2, r_prev;
  dir_t          r_mem [QUEUE_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  dir_t          r_dir;
  logic          r_turn, r_drop;

  logic [3:0]    w_press;
  logic [PW-1:0] w_last;
  dir_t          w_pdir, w_tail;
  logic          w_accept, w_pop, w_full, w_push, w_drop;

  // Released state is all-ones so leaving reset never looks like a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_comb begin
    w_press  = r_prev & ~r_sync2;
    w_pdir   = btn_to_dir(w_press);
    w_last   = r_wptr - 1'b1;
    w_tail   = (r_count != '0) ? r_mem[w_last] : r_dir;
    w_accept = (|w_press) && (w_pdir != w_tail) && (w_pdir != dir_rev(w_tail));
    w_full   = (r_count == C_FULL);
    w_pop    = step && (r_count != '0);
    w_push   = w_accept && (!w_full || w_pop);
    w_drop   = w_accept && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dir   <= RESET_DIR;
      r_turn  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_turn <= 1'b0;
      r_drop <= w_drop;
      if (w_pop) begin
        r_dir  <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
        r_turn <= 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_pdir;
    end
  end

  assign dir_out    = r_dir;
  assign turn_pulse = r_turn;
  assign drop_pulse = r_drop;
  assign q_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/snake_dir_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | snake_dir_queue                                                      |
// | Buffered multi-player direction queue; one channel per player.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module snake_dir_queue
  import snake_pkg::*;
#(
  parameter int   NUM_PLAYERS = 1,
  parameter int   QUEUE_DEPTH = 4,
  parameter dir_t RESET_DIR   = DIR_LEFT
) (
  input  logic       clk,
  input  logic       reset_n,
  snake_dir_if.slave bus
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [2*NUM_PLAYERS-1:0]  w_dir;
  logic [NUM_PLAYERS-1:0]    w_turn;
  logic [NUM_PLAYERS-1:0]    w_drop;
  logic [NUM_PLAYERS*CW-1:0] w_count;

  generate
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
      snake_dir_chan #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .RESET_DIR   (RESET_DIR)
      ) u_chan (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (bus.btn_n[4*p +: 4]),
        .step       (bus.step),
        .dir_out    (w_dir[2*p +: 2]),
        .turn_pulse (w_turn[p]),
        .drop_pulse (w_drop[p]),
        .q_count    (w_count[CW*p +: CW])
      );
    end
  endgenerate

  assign bus.dir_out    = w_dir;
  assign bus.turn_pulse = w_turn;
  assign bus.drop_pulse = w_drop;
  assign bus.q_count    = w_count;

endmodule
`default_nettype wire
